data_mem_responder: RTL

Word-organised data-memory target that answers load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. One request is in flight at a time, with a fixed parameterised access latency. It replaces the single-cycle data memory when multi-cycle memory timing is modelled. Addresses are byte addresses. Accesses are 32-bit words only.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types, constants and address checking for the data memory
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word compare avoids overflow of 4*depthWords for large memories.
  function automatic logic addrError(input logic [31:0] addr, input logic [31:0] depthWords);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depthWords);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port synchronous word RAM with registered read data
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Read-before-write: a store returns the old word, which the responder discards.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency load/store responder over valid/ready channels
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                 c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam int                 c_CNT_W    = $clog2(LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_rspErr;
  logic                r_rdValid;
  logic                w_accept;
  logic                w_exit;
  logic                w_err;
  logic                w_ramWe;
  logic [WORD_W-1:0]   w_ramRdata;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_exit   = (r_state == WAIT) && (r_cnt == '0);
  assign w_err    = addrError(r_addr, 32'(DEPTH_WORDS));
  // A reset landing on the exit edge must still suppress the write.
  assign w_ramWe  = w_exit && r_we && !w_err && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = WAIT;
      WAIT:    if (r_cnt == '0) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_err   = r_rspErr;
    // RAM address is held from accept through RESP, so its output stays stable.
    rsp_rdata = r_rdValid ? w_ramRdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rspErr  <= 1'b0;
      r_rdValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (w_exit) begin
        r_rspErr  <= w_err;
        r_rdValid <= !r_we && !w_err;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rspErr  <= 1'b0;
        r_rdValid <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_ramWe),
    .addr  (r_addr[c_IDX_W+1:2]),
    .wdata (r_wdata),
    .rdata (w_ramRdata)
  );

endmodule

`default_nettype wire
